// File: rtl/id_ex_skid.sv
// ID/EX pipeline register with a valid/ready handshake and a two-entry skid buffer.
// EX can stall without a combinational ready path back into decode; non-valid beats carry no live control.
module id_ex_skid #(
  parameter int DATA_W  = 64,
  parameter int PC_W    = 64,
  parameter int ALUOP_W = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PC_W-1:0]           pc,
  input  logic signed [DATA_W-1:0]  read1,
  input  logic signed [DATA_W-1:0]  read2,
  input  logic signed [DATA_W-1:0]  sign_extended,
  input  logic [31:0]               instruction,
  input  logic [ALUOP_W-1:0]        aluop,
  input  logic                      aluSrc,
  input  logic                      branch,
  input  logic                      uncond_branch,
  input  logic                      memread,
  input  logic                      memwrite,
  input  logic                      regWrite,
  input  logic                      memtoReg,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PC_W-1:0]           Pc,
  output logic signed [DATA_W-1:0]  Read1,
  output logic signed [DATA_W-1:0]  Read2,
  output logic signed [DATA_W-1:0]  Sign_extended,
  output logic [31:0]               Instruction_id_ex,
  output logic [10:0]               alu_ctrl_data,
  output logic [4:0]                write_reg,
  output logic [ALUOP_W-1:0]        Aluop,
  output logic                      ALUSrc,
  output logic                      Branch,
  output logic                      Uncond_Branch,
  output logic                      Memread,
  output logic                      Memwrite,
  output logic                      RegWrite,
  output logic                      MemtoReg,
  output logic [1:0]                occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]          pc;
    logic signed [DATA_W-1:0] read1;
    logic signed [DATA_W-1:0] read2;
    logic signed [DATA_W-1:0] sext;
    logic [31:0]              instr;
    logic [ALUOP_W-1:0]       aluop;
    logic                     alu_src;
    logic                     branch;
    logic                     uncond_branch;
    logic                     memread;
    logic                     memwrite;
    logic                     reg_write;
    logic                     mem_to_reg;
  } beat_t;

  state_t state;
  beat_t  in_beat_p0;
  beat_t  skid_p0;
  beat_t  main_p1;
  logic   vld_p1;
  logic   accept;
  logic   fire;

  // Strip every control field so a dead entry can never commit a side effect.
  function automatic beat_t squash(input beat_t b);
    beat_t r;
    r               = b;
    r.aluop         = '0;
    r.alu_src       = 1'b0;
    r.branch        = 1'b0;
    r.uncond_branch = 1'b0;
    r.memread       = 1'b0;
    r.memwrite      = 1'b0;
    r.reg_write     = 1'b0;
    r.mem_to_reg    = 1'b0;
    return r;
  endfunction

  always_comb begin
    in_beat_p0               = '0;
    in_beat_p0.pc            = pc;
    in_beat_p0.read1         = read1;
    in_beat_p0.read2         = read2;
    in_beat_p0.sext          = sign_extended;
    in_beat_p0.instr         = instruction;
    in_beat_p0.aluop         = aluop;
    in_beat_p0.alu_src       = aluSrc;
    in_beat_p0.branch        = branch;
    in_beat_p0.uncond_branch = uncond_branch;
    in_beat_p0.memread       = memread;
    in_beat_p0.memwrite      = memwrite;
    in_beat_p0.reg_write     = regWrite;
    in_beat_p0.mem_to_reg    = memtoReg;
  end

  // Handshake decoded from the state register only: no comb path from out_ready to in_ready.
  assign vld_p1    = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign out_valid = vld_p1;
  assign occupancy = state;
  assign accept    = in_valid & in_ready;
  assign fire      = vld_p1 & out_ready;

  // ---- p0 -> p1 boundary: skid/main update ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= EMPTY;
      main_p1 <= '0;
      skid_p0 <= '0;
    end else if (flush) begin
      state   <= EMPTY;
      main_p1 <= squash(main_p1);
      skid_p0 <= squash(skid_p0);
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_p1 <= in_beat_p0;
            state   <= ONE;
          end
        end
        ONE: begin
          if (accept && fire) begin
            main_p1 <= in_beat_p0;
          end else if (accept) begin
            skid_p0 <= in_beat_p0;
            state   <= FULL;
          end else if (fire) begin
            main_p1 <= squash(main_p1);
            state   <= EMPTY;
          end
        end
        FULL: begin
          if (fire) begin
            main_p1 <= skid_p0;
            skid_p0 <= squash(skid_p0);
            state   <= ONE;
          end
        end
        default: begin
          state   <= EMPTY;
          main_p1 <= squash(main_p1);
          skid_p0 <= squash(skid_p0);
        end
      endcase
    end
  end

  // ---- p1 output stage ----
  assign Pc                = main_p1.pc;
  assign Read1             = main_p1.read1;
  assign Read2             = main_p1.read2;
  assign Sign_extended     = main_p1.sext;
  assign Instruction_id_ex = main_p1.instr;
  assign alu_ctrl_data     = main_p1.instr[31:21];
  assign write_reg         = main_p1.instr[4:0];
  assign Aluop             = main_p1.aluop;
  assign ALUSrc            = main_p1.alu_src;
  assign Branch            = main_p1.branch;
  assign Uncond_Branch     = main_p1.uncond_branch;
  assign Memread           = main_p1.memread;
  assign Memwrite          = main_p1.memwrite;
  assign RegWrite          = main_p1.reg_write;
  assign MemtoReg          = main_p1.mem_to_reg;

endmodule

// File: tb/tb_id_ex_skid.sv
// Directed bench for id_ex_skid: a vector table for streaming, backpressure, flush and bubbles,
// plus hand sequences for reset with random inputs and reset while full.
module tb_id_ex_skid;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] pc, Pc;
  logic signed [63:0] read1, read2, sign_extended, Read1, Read2, Sign_extended;
  logic [31:0] instruction, Instruction_id_ex;
  logic [1:0]  aluop, Aluop, occupancy;
  logic        aluSrc, branch, uncond_branch, memread, memwrite, regWrite, memtoReg;
  logic        ALUSrc, Branch, Uncond_Branch, Memread, Memwrite, RegWrite, MemtoReg;
  logic [10:0] alu_ctrl_data;
  logic [4:0]  write_reg;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] INSTR = 32'h8B02_0020;

  id_ex_skid #(.DATA_W(64), .PC_W(64), .ALUOP_W(2)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .read1(read1), .read2(read2), .sign_extended(sign_extended),
    .instruction(instruction), .aluop(aluop), .aluSrc(aluSrc), .branch(branch),
    .uncond_branch(uncond_branch), .memread(memread), .memwrite(memwrite),
    .regWrite(regWrite), .memtoReg(memtoReg),
    .out_valid(out_valid), .out_ready(out_ready),
    .Pc(Pc), .Read1(Read1), .Read2(Read2), .Sign_extended(Sign_extended),
    .Instruction_id_ex(Instruction_id_ex), .alu_ctrl_data(alu_ctrl_data),
    .write_reg(write_reg), .Aluop(Aluop), .ALUSrc(ALUSrc), .Branch(Branch),
    .Uncond_Branch(Uncond_Branch), .Memread(Memread), .Memwrite(Memwrite),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, fl, iv, ordy;
    logic [63:0] ipc;
    logic        imw, irw;
    logic        ev, eir;
    logic [1:0]  eocc;
    logic [63:0] epc;
    logic        emw, erw;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic fl, input logic iv, input logic ordy,
                              input logic [63:0] ipc, input logic imw, input logic irw,
                              input logic ev, input logic eir, input logic [1:0] eocc,
                              input logic [63:0] epc, input logic emw, input logic erw);
    vec_t v;
    v.rst = 1'b0; v.fl = fl; v.iv = iv; v.ordy = ordy;
    v.ipc = ipc; v.imw = imw; v.irw = irw;
    v.ev = ev; v.eir = eir; v.eocc = eocc; v.epc = epc; v.emw = emw; v.erw = erw;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv, input logic ordy,
                       input logic [63:0] p, input logic mw, input logic rw);
    reset = rst; flush = fl; in_valid = iv; out_ready = ordy;
    pc = p; read1 = p + 64'h100; read2 = ~p; sign_extended = p << 1;
    instruction = INSTR; aluop = 2'b11;
    aluSrc = 1'b1; branch = 1'b1; uncond_branch = 1'b1; memread = 1'b1; memtoReg = 1'b1;
    memwrite = mw; regWrite = rw;
  endtask

  function automatic logic [8:0] ctrl_now();
    return {Aluop, ALUSrc, Branch, Uncond_Branch, Memread, Memwrite, RegWrite, MemtoReg};
  endfunction

  task automatic chk_reset_values(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_occupancy"}, occupancy, 2'd0);
    chk({tag, "_ctrl"}, ctrl_now(), 9'd0);
    chk({tag, "_data"}, {Pc, Read1, Read2, Sign_extended, Instruction_id_ex, alu_ctrl_data, write_reg}, '0);
  endtask

  initial begin
    // streaming: pc 0,4,8,12 one cycle later each
    tbl[0]  = mk(0, 1, 1, 64'h00, 0, 1,  1, 1, 2'd1, 64'h00, 0, 1);
    tbl[1]  = mk(0, 1, 1, 64'h04, 0, 1,  1, 1, 2'd1, 64'h04, 0, 1);
    tbl[2]  = mk(0, 1, 1, 64'h08, 0, 1,  1, 1, 2'd1, 64'h08, 0, 1);
    tbl[3]  = mk(0, 1, 1, 64'h0C, 0, 1,  1, 1, 2'd1, 64'h0C, 0, 1);
    tbl[4]  = mk(0, 0, 1, 64'h00, 0, 0,  0, 1, 2'd0, 64'h00, 0, 0);
    // backpressure: 0x10, 0x14 buffered, 0x18 held at ID until released
    tbl[5]  = mk(0, 1, 1, 64'h10, 0, 1,  1, 1, 2'd1, 64'h10, 0, 1);
    tbl[6]  = mk(0, 1, 0, 64'h14, 0, 1,  1, 0, 2'd2, 64'h10, 0, 1);
    tbl[7]  = mk(0, 1, 0, 64'h18, 0, 1,  1, 0, 2'd2, 64'h10, 0, 1);
    tbl[8]  = mk(0, 1, 1, 64'h18, 0, 1,  1, 1, 2'd1, 64'h14, 0, 1);
    tbl[9]  = mk(0, 1, 1, 64'h18, 0, 1,  1, 1, 2'd1, 64'h18, 0, 1);
    tbl[10] = mk(0, 0, 1, 64'h00, 0, 0,  0, 1, 2'd0, 64'h00, 0, 0);
    // flush while full with a memwrite beat and a concurrent input
    tbl[11] = mk(0, 1, 0, 64'h20, 1, 0,  1, 1, 2'd1, 64'h20, 1, 0);
    tbl[12] = mk(0, 1, 0, 64'h24, 1, 0,  1, 0, 2'd2, 64'h20, 1, 0);
    tbl[13] = mk(1, 1, 0, 64'h28, 1, 0,  0, 1, 2'd0, 64'h00, 0, 0);
    tbl[14] = mk(0, 0, 1, 64'h00, 0, 0,  0, 1, 2'd0, 64'h00, 0, 0);
    tbl[15] = mk(0, 1, 1, 64'h30, 0, 1,  1, 1, 2'd1, 64'h30, 0, 1);
    // bubbles: three idle cycles
    tbl[16] = mk(0, 0, 1, 64'h00, 0, 0,  0, 1, 2'd0, 64'h00, 0, 0);
    tbl[17] = mk(0, 0, 1, 64'h00, 0, 0,  0, 1, 2'd0, 64'h00, 0, 0);
    tbl[18] = mk(0, 0, 1, 64'h00, 0, 0,  0, 1, 2'd0, 64'h00, 0, 0);
    // fill up ahead of the reset-while-full sequence
    tbl[19] = mk(0, 1, 0, 64'h40, 1, 1,  1, 1, 2'd1, 64'h40, 1, 1);
    tbl[20] = mk(0, 1, 0, 64'h44, 1, 1,  1, 0, 2'd2, 64'h40, 1, 1);

    // reset for two cycles with random inputs
    drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      flush = 1'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
      pc = {$urandom, $urandom}; read1 = {$urandom, $urandom}; read2 = {$urandom, $urandom};
      sign_extended = {$urandom, $urandom}; instruction = $urandom; aluop = 2'($urandom);
      memwrite = 1'($urandom); regWrite = 1'($urandom);
      tick();
    end
    chk_reset_values("reset");

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].ipc, tbl[i].imw, tbl[i].irw);
      tick();
      chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].eir);
      chk($sformatf("v%0d_occupancy", i), occupancy, tbl[i].eocc);
      chk($sformatf("v%0d_ctrl", i), ctrl_now(),
          tbl[i].ev ? {2'b11, 1'b1, 1'b1, 1'b1, 1'b1, tbl[i].emw, tbl[i].erw, 1'b1} : 9'd0);
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_pc", i), Pc, tbl[i].epc);
        chk($sformatf("v%0d_read1", i), Read1, tbl[i].epc + 64'h100);
        chk($sformatf("v%0d_read2_sext", i), {Read2, Sign_extended}, {~tbl[i].epc, tbl[i].epc << 1});
        chk($sformatf("v%0d_alu_ctrl_data", i), alu_ctrl_data, 11'h458);
        chk($sformatf("v%0d_write_reg", i), write_reg, 5'd0);
      end
    end

    // reset in FULL together with flush and an accept
    drive(1'b1, 1'b1, 1'b1, 1'b1, 64'h48, 1'b1, 1'b1);
    tick();
    chk_reset_values("reset_full");

    // first accept after reset deassertion appears one cycle later
    drive(1'b0, 1'b0, 1'b1, 1'b1, 64'h50, 1'b0, 1'b1);
    tick();
    chk("post_reset_valid", out_valid, 1'b1);
    chk("post_reset_pc", Pc, 64'h50);
    chk("post_reset_instr", Instruction_id_ex, INSTR);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 1'b0, 1'b0);
    tick();
    chk("drain_valid", out_valid, 1'b0);
    chk("drain_ctrl", ctrl_now(), 9'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
